bp_be_issue_ctl: RTL

- Sequencing controller for the backend issue queue.
- Converts pipeline commit, replay and flush events into the queue's dequeue, roll and clear strobes.
- Gates reads from the queue (yumi) so the speculative in-flight window stays within a bound.
- Runs a small FSM that inserts recovery bubbles after a roll and drains the checkpoint after a flush.

---
 rtl/bp_be_issue_ctl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/bp_be_issue_ctl.sv
// bp_be_issue_ctl
//   Sequencing controller for the backend issue queue. It turns commit, replay
//   and flush events into the queue's dequeue (deq), roll and clear strobes,
//   throttles queue reads (yumi) so that no more than max_inflight_p entries
//   are read but uncommitted, and runs a small FSM:
//     e_run     - normal issue
//     e_recover - recover_cycles_p read-blocked bubbles after a roll
//     e_drain   - one forced deq per cycle until the checkpoint catches up
//
// Ports
//   clk_i, reset_i      clock, synchronous active-high reset
//   fe_queue_v_i        queue has a readable entry
//   dispatch_ready_i    dispatch can accept an instruction
//   commit_v_i          oldest in-flight instruction retired
//   replay_v_i          re-execute all uncommitted instructions
//   flush_v_i           redirect, discard unread and in-flight entries
//   fe_queue_yumi_o     read strobe to the queue
//   deq_v_o             checkpoint advance
//   roll_v_o            read pointer back to checkpoint
//   clr_v_o             write pointer back to read pointer
//   inflight_o          read-but-uncommitted count
//   busy_o              FSM is not in e_run
module bp_be_issue_ctl #(
  parameter int fe_queue_fifo_els_p = 16,
  parameter int max_inflight_p      = 8,
  parameter int recover_cycles_p    = 2,
  localparam int InfW = $clog2(max_inflight_p + 1),
  localparam int CntW = (recover_cycles_p > 1) ? $clog2(recover_cycles_p) : 1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            fe_queue_v_i,
  input  logic            dispatch_ready_i,
  input  logic            commit_v_i,
  input  logic            replay_v_i,
  input  logic            flush_v_i,
  output logic            fe_queue_yumi_o,
  output logic            deq_v_o,
  output logic            roll_v_o,
  output logic            clr_v_o,
  output logic [InfW-1:0] inflight_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {e_run, e_recover, e_drain} state_e;

  localparam logic [InfW-1:0] MaxInf    = InfW'(max_inflight_p);
  localparam logic [CntW-1:0] RecovInit = CntW'(recover_cycles_p - 1);

  state_e          r_state, w_state_n;
  logic [InfW-1:0] r_inflight, w_inflight_n, w_inflight_dec;
  logic [CntW-1:0] r_cnt, w_cnt_n;
  logic            w_yumi, w_deq, w_roll, w_clr;

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= e_run;
      r_inflight <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_n;
      r_inflight <= w_inflight_n;
      r_cnt      <= w_cnt_n;
    end
  end

  // Raw strobes, before reset gating; the next-state logic consumes these.
  always_comb begin
    w_yumi = 1'b0;
    w_deq  = commit_v_i & (r_inflight != '0);
    w_roll = 1'b0;
    w_clr  = 1'b0;
    unique case (r_state)
      e_run: begin
        w_yumi = fe_queue_v_i & dispatch_ready_i & (r_inflight < MaxInf)
               & ~flush_v_i & ~replay_v_i;
        if (flush_v_i)       w_clr  = 1'b1;
        else if (replay_v_i) w_roll = 1'b1;
      end
      e_recover: w_clr = flush_v_i;
      e_drain: begin
        // Drain advances the checkpoint on its own; commits add nothing.
        w_deq = (r_inflight != '0);
        w_clr = flush_v_i;
      end
      default: ;
    endcase
  end

  assign w_inflight_dec = r_inflight - InfW'(w_deq);

  // Next-state logic
  always_comb begin
    w_state_n    = r_state;
    w_inflight_n = r_inflight;
    w_cnt_n      = r_cnt;
    unique case (r_state)
      e_run: begin
        if (flush_v_i) begin
          w_inflight_n = w_inflight_dec;
          w_state_n    = (w_inflight_dec == '0) ? e_run : e_drain;
        end else if (replay_v_i) begin
          // The same-cycle deq is folded into the roll by the queue.
          w_inflight_n = '0;
          w_cnt_n      = RecovInit;
          w_state_n    = e_recover;
        end else begin
          w_inflight_n = r_inflight + InfW'(w_yumi) - InfW'(w_deq);
        end
      end
      e_recover: begin
        if (flush_v_i) begin
          w_cnt_n   = '0;
          w_state_n = e_run;
        end else if (r_cnt == '0) begin
          w_state_n = e_run;
        end else begin
          w_cnt_n = r_cnt - 1'b1;
        end
      end
      e_drain: begin
        w_inflight_n = w_inflight_dec;
        if (w_inflight_dec == '0) w_state_n = e_run;
      end
      default: w_state_n = e_run;
    endcase
  end

  // Outputs: everything is held low while reset is asserted.
  always_comb begin
    fe_queue_yumi_o = ~reset_i & w_yumi;
    deq_v_o         = ~reset_i & w_deq;
    roll_v_o        = ~reset_i & w_roll;
    clr_v_o         = ~reset_i & w_clr;
    busy_o          = ~reset_i & (r_state != e_run);
    inflight_o      = reset_i ? '0 : r_inflight;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(commit_v_i && r_inflight == '0));
      assert (r_inflight <= MaxInf);
      assert (max_inflight_p >= 1 && max_inflight_p <= fe_queue_fifo_els_p);
    end
  end

endmodule
